sync_updown_counter: RTL

Parametrised synchronous up/down counter, replacing the 3-bit ripple counter in new designs. All bits switch on one clock edge, so there is no ripple skew. Supports a programmable modulus, parallel load, count enable, direction select, wrap or saturate mode, a terminal-count pulse and a sticky overflow flag. Intended as the general-purpose event/timer counter for the rest of the design.

---
 rtl/sync_updown_counter_if.sv | 31 +++
 rtl/sync_updown_counter.sv | 81 ++++++++
 2 files changed

// File: rtl/sync_updown_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : sync_updown_counter_if
//  Description : Control/status bundle for sync_updown_counter.
//  Revision    : 1.0  initial release
// ============================================================================
interface sync_updown_counter_if #(
   parameter int WIDTH = 3
);
   logic             en;
   logic             up;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             sat;
   logic             clr_ovf;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             ovf;
   logic             zero;

   modport master (
      output en, up, load, load_val, sat, clr_ovf,
      input  count, tc, ovf, zero
   );

   modport slave (
      input  en, up, load, load_val, sat, clr_ovf,
      output count, tc, ovf, zero
   );
endinterface
`default_nettype wire

// File: rtl/sync_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sync_updown_counter
//  Description : Synchronous up/down counter with programmable modulus,
//                parallel load, wrap/saturate, terminal count and sticky ovf.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_updown_counter #(
   parameter int WIDTH     = 3,
   parameter int MAX_COUNT = 2**WIDTH - 1,
   parameter int RST_VAL   = 0
) (
   input wire logic             clk,
   input wire logic             rst,
   sync_updown_counter_if.slave bus
);

   localparam logic [WIDTH-1:0] c_max  = WIDTH'(MAX_COUNT);
   localparam logic [WIDTH-1:0] c_rst  = WIDTH'(RST_VAL);
   localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);
   localparam logic [WIDTH-1:0] c_zero = '0;

   logic [WIDTH-1:0] r_count;
   logic             r_tc;
   logic             r_ovf;

   logic [WIDTH-1:0] w_next;
   logic [WIDTH-1:0] w_load_val;
   logic             w_at_max;
   logic             w_at_zero;
   logic             w_boundary;

   // Boundaries are compared against MAX_COUNT so short moduli never roll
   // through the unused top codes.
   always_comb begin
      w_load_val = (bus.load_val > c_max) ? c_max : bus.load_val;
      w_at_max   = (r_count == c_max);
      w_at_zero  = (r_count == c_zero);
      w_boundary = 1'b0;
      w_next     = r_count;
      if (bus.load) begin
         w_next = w_load_val;
      end else if (bus.en) begin
         if (bus.up) begin
            if (w_at_max) begin
               w_boundary = 1'b1;
               w_next     = bus.sat ? c_max : c_zero;
            end else begin
               w_next = r_count + c_one;
            end
         end else begin
            if (w_at_zero) begin
               w_boundary = 1'b1;
               w_next     = bus.sat ? c_zero : c_max;
            end else begin
               w_next = r_count - c_one;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= c_rst;
         r_tc    <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_count <= w_next;
         r_tc    <= w_boundary;
         // A boundary event on the same edge as a clear leaves the flag set
         r_ovf   <= w_boundary | (r_ovf & ~bus.clr_ovf);
      end
   end

   assign bus.count = r_count;
   assign bus.tc    = r_tc;
   assign bus.ovf   = r_ovf;
   assign bus.zero  = (r_count == c_zero);

endmodule
`default_nettype wire
